// File: rtl/zap_mem_inv_pkg.sv
// Shared types and default sizes for the
// set-associative tag/payload store.
package zap_mem_inv_pkg;

  localparam int SETS_D = 16;
  localparam int WAYS_D = 4;
  localparam int TAG_WD = 20;
  localparam int DATA_WD = 32;

  localparam int IDX_W = $clog2(SETS_D);
  localparam int WAY_W = $clog2(WAYS_D);

  typedef struct packed {
    logic               valid;
    logic [TAG_WD-1:0]  tag;
    logic [DATA_WD-1:0] data;
  } mem_entry_t;

endpackage

// File: rtl/mem_inv_victim.sv
// Write-port way selection: update in place,
// then lowest invalid way, then round-robin.
module mem_inv_victim
  import zap_mem_inv_pkg::*;
#(
  parameter int WAYS = 4,
  parameter int WW   = $clog2(WAYS)
) (
  input  logic [WAYS-1:0] i_valid,
  input  logic [WAYS-1:0] i_match,
  input  logic [WW-1:0]   i_ptr,
  output logic [WW-1:0]   o_way,
  output logic            o_adv
);

  // pick the target way; only a full miss advances the pointer
  always_comb begin
    o_way = i_ptr;
    o_adv = 1'b0;
    priority case (1'b1)
      (|i_match): begin
        for (int i = 0; i < WAYS; i++)
          if (i_match[i]) o_way = i[WW-1:0];
      end
      (!(&i_valid)): begin
        for (int i = WAYS - 1; i >= 0; i--)
          if (!i_valid[i]) o_way = i[WW-1:0];
      end
      default: o_adv = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_inv_assoc.sv
// N-way set-associative tag/payload store with
// single-cycle flush and per-line invalidate.
module mem_inv_assoc
  import zap_mem_inv_pkg::*;
#(
  parameter int SETS   = 16,
  parameter int WAYS   = 4,
  parameter int TAG_W  = 20,
  parameter int DATA_W = 32
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_lkp_en,
  input  logic [$clog2(SETS)-1:0] i_lkp_idx,
  input  logic [TAG_W-1:0]        i_lkp_tag,
  input  logic                    i_wen,
  input  logic [$clog2(SETS)-1:0] i_w_idx,
  input  logic [TAG_W-1:0]        i_w_tag,
  input  logic [DATA_W-1:0]       i_w_data,
  input  logic                    i_inv_all,
  input  logic                    i_inv_line,
  input  logic [$clog2(SETS)-1:0] i_inv_idx,
  input  logic [TAG_W-1:0]        i_inv_tag,
  output logic                    o_rvalid,
  output logic                    o_hit,
  output logic [$clog2(WAYS)-1:0] o_hit_way,
  output logic [DATA_W-1:0]       o_rdata
);

  localparam int WW = $clog2(WAYS);

  logic [WAYS-1:0]   r_valid [SETS];
  logic [WW-1:0]     r_ptr   [SETS];
  logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
  logic [DATA_W-1:0] r_data  [SETS][WAYS];

  logic [WAYS-1:0]   w_lkp_match;
  logic [WAYS-1:0]   w_wr_match;
  logic [WAYS-1:0]   w_inv_match;
  logic              w_lkp_hit;
  logic [WW-1:0]     w_lkp_way;
  logic [DATA_W-1:0] w_lkp_data;
  logic [WW-1:0]     w_vic_way;
  logic              w_vic_adv;

  genvar g;
  for (g = 0; g < WAYS; g++) begin : g_cmp
    assign w_lkp_match[g] = r_valid[i_lkp_idx][g] &&
      (r_tag[i_lkp_idx][g] == i_lkp_tag);
    assign w_wr_match[g] = r_valid[i_w_idx][g] &&
      (r_tag[i_w_idx][g] == i_w_tag);
    assign w_inv_match[g] = r_valid[i_inv_idx][g] &&
      (r_tag[i_inv_idx][g] == i_inv_tag);
  end

  // encode the (at most one) matching lookup way
  always_comb begin
    w_lkp_way = '0;
    for (int i = 0; i < WAYS; i++)
      if (w_lkp_match[i]) w_lkp_way = i[WW-1:0];
  end

  assign w_lkp_hit  = |w_lkp_match;
  assign w_lkp_data = r_data[i_lkp_idx][w_lkp_way];

  mem_inv_victim #(
    .WAYS (WAYS),
    .WW   (WW)
  ) u_victim (
    .i_valid (r_valid[i_w_idx]),
    .i_match (w_wr_match),
    .i_ptr   (r_ptr[i_w_idx]),
    .o_way   (w_vic_way),
    .o_adv   (w_vic_adv)
  );

  // valid bits, pointers and registered lookup result
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_ptr[s]   <= '0;
      end
      o_rvalid  <= 1'b0;
      o_hit     <= 1'b0;
      o_hit_way <= '0;
      o_rdata   <= '0;
    end else begin
      o_rvalid <= i_lkp_en;
      if (i_lkp_en) begin
        if (i_inv_all) begin
          o_hit     <= 1'b0;
          o_hit_way <= '0;
        end else begin
          o_hit     <= w_lkp_hit;
          o_hit_way <= w_lkp_hit ? w_lkp_way : '0;
          if (w_lkp_hit) o_rdata <= w_lkp_data;
        end
      end
      if (i_inv_all) begin
        for (int s = 0; s < SETS; s++) begin
          r_valid[s] <= '0;
          r_ptr[s]   <= '0;
        end
      end else begin
        if (i_inv_line)
          r_valid[i_inv_idx] <= r_valid[i_inv_idx] & ~w_inv_match;
        // a write to the same way overrides the invalidate
        if (i_wen) begin
          r_valid[i_w_idx][w_vic_way] <= 1'b1;
          if (w_vic_adv)
            r_ptr[i_w_idx] <= r_ptr[i_w_idx] + 1'b1;
        end
      end
    end
  end

  // tag and payload storage, no reset
  always_ff @(posedge i_clk) begin
    if (!i_reset && !i_inv_all && i_wen) begin
      r_tag[i_w_idx][w_vic_way]  <= i_w_tag;
      r_data[i_w_idx][w_vic_way] <= i_w_data;
    end
  end

endmodule

// File: tb/tb_mem_inv_assoc.sv
// Randomised and directed checks of mem_inv_assoc
// against a behavioural set-associative model.
module tb_mem_inv_assoc;
  import zap_mem_inv_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_lkp_en;
  logic [3:0]  i_lkp_idx;
  logic [19:0] i_lkp_tag;
  logic        i_wen;
  logic [3:0]  i_w_idx;
  logic [19:0] i_w_tag;
  logic [31:0] i_w_data;
  logic        i_inv_all;
  logic        i_inv_line;
  logic [3:0]  i_inv_idx;
  logic [19:0] i_inv_tag;
  logic        o_rvalid;
  logic        o_hit;
  logic [1:0]  o_hit_way;
  logic [31:0] o_rdata;

  mem_inv_assoc dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_lkp_en   (i_lkp_en),
    .i_lkp_idx  (i_lkp_idx),
    .i_lkp_tag  (i_lkp_tag),
    .i_wen      (i_wen),
    .i_w_idx    (i_w_idx),
    .i_w_tag    (i_w_tag),
    .i_w_data   (i_w_data),
    .i_inv_all  (i_inv_all),
    .i_inv_line (i_inv_line),
    .i_inv_idx  (i_inv_idx),
    .i_inv_tag  (i_inv_tag),
    .o_rvalid   (o_rvalid),
    .o_hit      (o_hit),
    .o_hit_way  (o_hit_way),
    .o_rdata    (o_rdata)
  );

  always #5 i_clk = ~i_clk;

  int n_chk  = 0;
  int n_fail = 0;

  mem_entry_t m_ent [16][4];
  int         m_ptr [16];

  logic        e_rv;
  logic        e_hit;
  logic [1:0]  e_way;
  logic [31:0] e_rdata;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int find(input int s, input logic [19:0] t);
    for (int w = 0; w < 4; w++)
      if (m_ent[s][w].valid && m_ent[s][w].tag == t) return w;
    return -1;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 16; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < 4; w++) m_ent[s][w].valid = 1'b0;
    end
    e_rv = 0; e_hit = 0; e_way = 0; e_rdata = 0;
  endtask

  task automatic clear_in();
    i_lkp_en = 0; i_lkp_idx = 0; i_lkp_tag = 0;
    i_wen = 0; i_w_idx = 0; i_w_tag = 0; i_w_data = 0;
    i_inv_all = 0; i_inv_line = 0;
    i_inv_idx = 0; i_inv_tag = 0;
  endtask

  // one cycle: predict, clock, compare, advance model
  task automatic tick();
    int hw, ws, s, iw;
    e_rv = i_lkp_en;
    if (i_lkp_en) begin
      if (i_inv_all) begin
        e_hit = 0; e_way = 0;
      end else begin
        hw = find(int'(i_lkp_idx), i_lkp_tag);
        e_hit = (hw >= 0);
        e_way = (hw >= 0) ? hw[1:0] : 2'd0;
        if (hw >= 0) e_rdata = m_ent[i_lkp_idx][hw].data;
      end
    end
    @(posedge i_clk);
    #1;
    chk("rvalid", {63'd0, o_rvalid}, {63'd0, e_rv});
    chk("hit", {63'd0, o_hit}, {63'd0, e_hit});
    chk("hit_way", {62'd0, o_hit_way}, {62'd0, e_way});
    chk("rdata", {32'd0, o_rdata}, {32'd0, e_rdata});
    if (i_inv_all) begin
      for (s = 0; s < 16; s++) begin
        m_ptr[s] = 0;
        for (int w = 0; w < 4; w++) m_ent[s][w].valid = 1'b0;
      end
    end else begin
      s = int'(i_w_idx);
      ws = -1;
      if (i_wen) begin
        ws = find(s, i_w_tag);
        if (ws < 0)
          for (int w = 3; w >= 0; w--)
            if (!m_ent[s][w].valid) ws = w;
        if (ws < 0) begin
          ws = m_ptr[s];
          m_ptr[s] = (m_ptr[s] + 1) % 4;
        end
      end
      if (i_inv_line) begin
        iw = find(int'(i_inv_idx), i_inv_tag);
        if (iw >= 0) m_ent[i_inv_idx][iw].valid = 1'b0;
      end
      if (i_wen) begin
        m_ent[s][ws].valid = 1'b1;
        m_ent[s][ws].tag   = i_w_tag;
        m_ent[s][ws].data  = i_w_data;
      end
    end
    clear_in();
  endtask

  task automatic do_wr(input int idx, input int tag, input int data);
    i_wen = 1; i_w_idx = idx[3:0];
    i_w_tag = tag[19:0]; i_w_data = data;
    tick();
  endtask

  task automatic do_lkp(input int idx, input int tag);
    i_lkp_en = 1; i_lkp_idx = idx[3:0]; i_lkp_tag = tag[19:0];
    tick();
  endtask

  task automatic do_reset(input int cycles);
    i_reset = 1;
    for (int c = 0; c < cycles; c++) begin
      i_lkp_en = 1; i_lkp_idx = 4'd3; i_lkp_tag = 20'h12345;
      @(posedge i_clk);
      #1;
      chk("rst_rvalid", {63'd0, o_rvalid}, 64'd0);
      chk("rst_hit", {63'd0, o_hit}, 64'd0);
      chk("rst_way", {62'd0, o_hit_way}, 64'd0);
      chk("rst_rdata", {32'd0, o_rdata}, 64'd0);
    end
    i_reset = 0;
    clear_in();
    model_reset();
  endtask

  initial begin
    clear_in();
    i_reset = 1;
    model_reset();
    @(negedge i_clk);
    do_reset(2);

    do_lkp(3, 'h12345);
    chk("plan_miss_rv", {63'd0, o_rvalid}, 64'd1);
    chk("plan_miss_hit", {63'd0, o_hit}, 64'd0);

    do_wr(5, 'hA, 1);
    do_wr(5, 'hB, 2);
    do_wr(5, 'hC, 3);
    do_wr(5, 'hD, 4);
    do_lkp(5, 'hC);
    chk("plan_c_hit", {63'd0, o_hit}, 64'd1);
    chk("plan_c_way", {62'd0, o_hit_way}, 64'd2);
    chk("plan_c_data", {32'd0, o_rdata}, 64'd3);
    do_wr(5, 'hE, 5);
    do_wr(5, 'hF, 6);
    do_lkp(5, 'hA);
    chk("plan_a_miss", {63'd0, o_hit}, 64'd0);
    do_wr(5, 'hE, 9);
    do_lkp(5, 'hE);
    chk("plan_e_way", {62'd0, o_hit_way}, 64'd0);
    chk("plan_e_data", {32'd0, o_rdata}, 64'd9);
    i_inv_line = 1; i_inv_idx = 4'd5; i_inv_tag = 20'hF;
    tick();
    do_wr(5, 'h10, 7);
    do_lkp(5, 'h10);
    chk("plan_10_way", {62'd0, o_hit_way}, 64'd1);
    do_lkp(5, 'hC);
    chk("plan_c_kept", {62'd0, o_hit_way}, 64'd2);

    for (int s = 0; s < 16; s++) do_wr(s, 'h20 + s, s);
    i_inv_all = 1;
    i_wen = 1; i_w_idx = 4'd2; i_w_tag = 20'h55; i_w_data = 32'h55;
    i_lkp_en = 1; i_lkp_idx = 4'd0; i_lkp_tag = 20'h20;
    tick();
    chk("flush_lkp_rv", {63'd0, o_rvalid}, 64'd1);
    chk("flush_lkp_hit", {63'd0, o_hit}, 64'd0);
    for (int s = 0; s < 16; s++) begin
      do_lkp(s, 'h20 + s);
      chk("flush_miss", {63'd0, o_hit}, 64'd0);
    end
    do_lkp(2, 'h55);
    chk("flush_wr_drop", {63'd0, o_hit}, 64'd0);
    do_wr(9, 'h77, 'h77);
    do_lkp(9, 'h77);
    chk("flush_way0", {62'd0, o_hit_way}, 64'd0);
    chk("flush_hit", {63'd0, o_hit}, 64'd1);

    i_wen = 1; i_w_idx = 4'd7; i_w_tag = 20'h3; i_w_data = 32'h33;
    i_lkp_en = 1; i_lkp_idx = 4'd7; i_lkp_tag = 20'h3;
    tick();
    chk("same_cyc_miss", {63'd0, o_hit}, 64'd0);
    do_lkp(7, 'h3);
    chk("next_cyc_hit", {63'd0, o_hit}, 64'd1);

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset(1);
      end else begin
        i_lkp_en   = ($urandom_range(0, 1) == 1);
        i_lkp_idx  = ($urandom_range(0, 1) == 1) ?
                     4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
        i_lkp_tag  = 20'($urandom_range(0, 7));
        i_wen      = ($urandom_range(0, 2) != 0);
        i_w_idx    = ($urandom_range(0, 1) == 1) ?
                     4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
        i_w_tag    = 20'($urandom_range(0, 7));
        i_w_data   = $urandom;
        i_inv_all  = ($urandom_range(0, 79) == 0);
        i_inv_line = ($urandom_range(0, 3) == 0);
        i_inv_idx  = ($urandom_range(0, 1) == 1) ?
                     i_w_idx : 4'($urandom_range(0, 2));
        i_inv_tag  = 20'($urandom_range(0, 7));
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
